// File: rtl/n64_joybus_rx.sv
// N64 joybus receiver: measures low-pulse widths on the synchronized line, recovers MSB-first
// bits, and emits bytes plus a frame_done/frame_err strobe once the line idles.
module n64_joybus_rx #(
    parameter int unsigned CYCLES_PER_US = 50,
    parameter int unsigned MAX_BYTES     = 40
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       data_in,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic [5:0] byte_idx,
    output logic       frame_done,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned LOW_THRESH   = 2 * CYCLES_PER_US;
    localparam int unsigned LOW_MAX      = 5 * CYCLES_PER_US;
    localparam int unsigned IDLE_TIMEOUT = 4 * CYCLES_PER_US;

    localparam logic [15:0] LowThresh16   = 16'(LOW_THRESH);
    localparam logic [15:0] LowMax16      = 16'(LOW_MAX);
    localparam logic [15:0] IdleTimeout16 = 16'(IDLE_TIMEOUT);
    localparam logic [5:0]  MaxBytes6     = 6'(MAX_BYTES);

    typedef enum logic [2:0] {
        StSync,
        StIdle,
        StLow,
        StHigh,
        StErrWait
    } state_e;

    state_e      state_q;
    logic        meta_q;
    logic        sl_q;
    logic        prev_q;
    logic [15:0] low_cnt_q;
    logic [15:0] high_cnt_q;
    logic [6:0]  shift_q;
    logic [2:0]  bit_cnt_q;
    logic [5:0]  byte_cnt_q;

    logic fall;
    logic new_bit;
    logic stop_ok;

    always_comb begin
        fall    = prev_q & ~sl_q;
        new_bit = (low_cnt_q < LowThresh16);
        // A good frame ends with exactly one leftover bit, a 1, after at least one full byte.
        stop_ok = (bit_cnt_q == 3'd1) && shift_q[0] && (byte_cnt_q != 6'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StSync;
            meta_q     <= 1'b1;
            sl_q       <= 1'b1;
            prev_q     <= 1'b1;
            low_cnt_q  <= 16'd0;
            high_cnt_q <= 16'd0;
            shift_q    <= 7'd0;
            bit_cnt_q  <= 3'd0;
            byte_cnt_q <= 6'd0;
            byte_data  <= 8'd0;
            byte_valid <= 1'b0;
            byte_idx   <= 6'd0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            meta_q     <= data_in;
            sl_q       <= meta_q;
            prev_q     <= sl_q;
            byte_valid <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;

            unique case (state_q)
                StSync, StErrWait: begin
                    if (!sl_q) begin
                        high_cnt_q <= 16'd0;
                    end else if (high_cnt_q + 16'd1 == IdleTimeout16) begin
                        high_cnt_q <= 16'd0;
                        state_q    <= StIdle;
                    end else begin
                        high_cnt_q <= high_cnt_q + 16'd1;
                    end
                end
                StIdle: begin
                    if (fall) begin
                        state_q    <= StLow;
                        busy       <= 1'b1;
                        bit_cnt_q  <= 3'd0;
                        byte_cnt_q <= 6'd0;
                        low_cnt_q  <= 16'd1;
                    end
                end
                StLow: begin
                    if (sl_q) begin
                        shift_q    <= {shift_q[5:0], new_bit};
                        high_cnt_q <= 16'd1;
                        state_q    <= StHigh;
                        bit_cnt_q  <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (byte_cnt_q == MaxBytes6) begin
                                frame_err <= 1'b1;
                                busy      <= 1'b0;
                                state_q   <= StErrWait;
                            end else begin
                                byte_valid <= 1'b1;
                                byte_data  <= {shift_q, new_bit};
                                byte_idx   <= byte_cnt_q;
                                byte_cnt_q <= byte_cnt_q + 6'd1;
                            end
                        end
                    end else if (low_cnt_q + 16'd1 == LowMax16) begin
                        frame_err  <= 1'b1;
                        busy       <= 1'b0;
                        high_cnt_q <= 16'd0;
                        state_q    <= StErrWait;
                    end else if (low_cnt_q != 16'hFFFF) begin
                        low_cnt_q <= low_cnt_q + 16'd1;
                    end
                end
                StHigh: begin
                    if (!sl_q) begin
                        low_cnt_q <= 16'd1;
                        state_q   <= StLow;
                    end else if (high_cnt_q + 16'd1 == IdleTimeout16) begin
                        busy       <= 1'b0;
                        high_cnt_q <= 16'd0;
                        state_q    <= StIdle;
                        if (stop_ok) begin
                            frame_done <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        high_cnt_q <= high_cnt_q + 16'd1;
                    end
                end
                default: state_q <= StSync;
            endcase
        end
    end

endmodule

// File: tb/tb_n64_joybus_rx.sv
// Directed bench for n64_joybus_rx: drives joybus waveforms and checks decoded bytes,
// frame strobes and their latencies against hand-computed values.
module tb_n64_joybus_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       data_in = 1'b1;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic [5:0] byte_idx;
    logic       frame_done;
    logic       frame_err;
    logic       busy;

    n64_joybus_rx #(
        .CYCLES_PER_US(50),
        .MAX_BYTES    (40)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_in   (data_in),
        .byte_data (byte_data),
        .byte_valid(byte_valid),
        .byte_idx  (byte_idx),
        .frame_done(frame_done),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    logic [13:0] bv_q[$];
    int n_done, n_ferr, done_cyc, err_cyc, bv_lat, last_rise_cyc, stop_rise_cyc, fall_cyc;
    bit both_seen, busy_seen;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (byte_valid) begin
            if (bv_q.size() == 0) bv_lat = cyc - last_rise_cyc;
            bv_q.push_back({byte_idx, byte_data});
        end
        if (frame_done) begin
            n_done++;
            done_cyc = cyc;
        end
        if (frame_err) begin
            if (n_ferr == 0) err_cyc = cyc;
            n_ferr++;
        end
        if (frame_done && frame_err) both_seen = 1'b1;
        if (busy) busy_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] q_data(input int k);
        logic [13:0] e;
        if (k >= bv_q.size()) return 32'hxxxxxxxx;
        e = bv_q[k];
        return {24'd0, e[7:0]};
    endfunction

    function automatic logic [31:0] q_idx(input int k);
        logic [13:0] e;
        if (k >= bv_q.size()) return 32'hxxxxxxxx;
        e = bv_q[k];
        return {26'd0, e[13:8]};
    endfunction

    task automatic clear_log();
        bv_q.delete();
        n_done    = 0;
        n_ferr    = 0;
        done_cyc  = 0;
        err_cyc   = 0;
        bv_lat    = 0;
        both_seen = 1'b0;
        busy_seen = 1'b0;
    endtask

    task automatic drive(input logic v, input int n);
        data_in = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_pulse(input int lo, input int hi);
        drive(1'b0, lo);
        last_rise_cyc = cyc;
        drive(1'b1, hi);
    endtask

    task automatic send_bit(input logic b);
        if (b) send_pulse(50, 150);
        else   send_pulse(150, 50);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic send_stop();
        drive(1'b0, 50);
        stop_rise_cyc = cyc;
        drive(1'b1, 250);
    endtask

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: got cycle budget exhausted, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_log();
        // Reset values
        repeat (5) @(negedge clk);
        check("rst_byte_data", {24'd0, byte_data}, 32'd0);
        check("rst_byte_valid", {31'd0, byte_valid}, 32'd0);
        check("rst_byte_idx", {26'd0, byte_idx}, 32'd0);
        check("rst_frame_done", {31'd0, frame_done}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        drive(1'b1, 300);

        // Reset in the middle of a frame
        send_bit(1'b1);
        send_bit(1'b0);
        drive(1'b0, 30);
        check("mid_busy_before_rst", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_strobes", {29'd0, byte_valid, frame_done, frame_err}, 32'd0);
        drive(1'b1, 3);
        rst_n = 1'b1;
        clear_log();
        drive(1'b1, 100);
        drive(1'b0, 50);
        drive(1'b1, 100);
        send_byte(8'h00);
        send_stop();
        check("sync_no_busy", {31'd0, busy_seen}, 32'd0);
        check("sync_no_bytes", bv_q.size(), 32'd0);
        check("sync_no_frame", n_done + n_ferr, 32'd0);

        // Status command 0x00
        clear_log();
        send_byte(8'h00);
        send_stop();
        check("status_count", bv_q.size(), 32'd1);
        check("status_data", q_data(0), 32'h00);
        check("status_idx", q_idx(0), 32'd0);
        check("status_bv_latency", bv_lat, 32'd3);
        check("status_done", n_done, 32'd1);
        check("status_err", n_ferr, 32'd0);
        check("status_done_latency", done_cyc - stop_rise_cyc, 32'd202);
        check("status_busy_after", {31'd0, busy}, 32'd0);

        // Three-byte write
        clear_log();
        send_byte(8'h03);
        send_byte(8'h80);
        send_byte(8'hA5);
        send_stop();
        check("wr_count", bv_q.size(), 32'd3);
        check("wr_data0", q_data(0), 32'h03);
        check("wr_idx0", q_idx(0), 32'd0);
        check("wr_data1", q_data(1), 32'h80);
        check("wr_idx1", q_idx(1), 32'd1);
        check("wr_data2", q_data(2), 32'hA5);
        check("wr_idx2", q_idx(2), 32'd2);
        check("wr_done", n_done, 32'd1);
        check("wr_err", n_ferr, 32'd0);
        check("wr_hold", {24'd0, byte_data}, 32'hA5);

        // Threshold boundary: 99 low decodes 1, 100 low decodes 0
        clear_log();
        for (int i = 0; i < 4; i++) begin
            send_pulse(100, 100);
            send_pulse(99, 101);
        end
        send_stop();
        check("thr_data", q_data(0), 32'h55);
        check("thr_done", n_done, 32'd1);

        // Long low mid-frame
        clear_log();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        fall_cyc = cyc;
        drive(1'b0, 250);
        drive(1'b1, 100);
        check("long_err", n_ferr, 32'd1);
        check("long_err_latency", err_cyc - fall_cyc, 32'd252);
        check("long_busy", {31'd0, busy}, 32'd0);
        check("long_no_bytes", bv_q.size(), 32'd0);
        send_byte(8'hFF);
        send_stop();
        check("errwait_no_bytes", bv_q.size(), 32'd0);
        check("errwait_no_frame", n_done + n_ferr, 32'd1);
        send_byte(8'h12);
        send_stop();
        check("recover_data", q_data(0), 32'h12);
        check("recover_done", n_done, 32'd1);

        // Seven bits then idle
        clear_log();
        for (int i = 0; i < 7; i++) send_bit(1'(i % 2 == 0));
        drive(1'b1, 250);
        check("seven_err", n_ferr, 32'd1);
        check("seven_no_bytes", bv_q.size(), 32'd0);
        check("seven_no_done", n_done, 32'd0);

        // A lone stop bit has no bytes
        clear_log();
        send_stop();
        check("lone_stop_err", n_ferr, 32'd1);
        check("lone_stop_done", n_done, 32'd0);

        // One byte plus two trailing bits
        clear_log();
        send_byte(8'hC3);
        send_bit(1'b1);
        send_bit(1'b1);
        drive(1'b1, 250);
        check("trail_data", q_data(0), 32'hC3);
        check("trail_count", bv_q.size(), 32'd1);
        check("trail_err", n_ferr, 32'd1);
        check("trail_done", n_done, 32'd0);

        // 41 bytes overflow; fast but legal bit timing
        clear_log();
        for (int b = 0; b < 41; b++) begin
            logic [7:0] v;
            v = ~8'(b);
            for (int i = 7; i >= 0; i--) begin
                if (v[i]) send_pulse(20, 30);
                else      send_pulse(120, 30);
            end
        end
        send_stop();
        check("ovf_count", bv_q.size(), 32'd40);
        check("ovf_last_idx", q_idx(39), 32'd39);
        check("ovf_last_data", q_data(39), 32'hD8);
        check("ovf_err", n_ferr, 32'd1);
        check("ovf_done", n_done, 32'd0);
        check("ovf_busy", {31'd0, busy}, 32'd0);
        check("never_both_strobes", {31'd0, both_seen}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/n64_joybus_rx.md
# n64_joybus_rx

Single-wire N64 joybus receiver that consumes the console-side data line (the recorded capture replay in simulation, the real controller-port line in hardware) and decodes it into bytes. It measures each low pulse to recover MSB-first bits. It emits each completed byte with a one-cycle strobe and flags frame completion or error after the line goes idle. Downstream command decoding consumes its byte stream.

## Interface
- CYCLES_PER_US, 50, clock cycles per microsecond.
  - Derived localparams:
    - LOW_THRESH = 2*CYCLES_PER_US
    - LOW_MAX = 5*CYCLES_PER_US
    - IDLE_TIMEOUT = 4*CYCLES_PER_US
- MAX_BYTES, 40, maximum data bytes per frame before error.
- Ports:
  - clk  in  1  system clock. One clock.
  - rst_n  in  1  reset. Asynchronous, active-low.
  - data_in  in  1  joybus line. Asynchronous to clk; idles high.
  - byte_data  out  8  last completed byte, MSB first on the wire.
  - byte_valid  out  1  one-cycle strobe; byte_data/byte_idx valid this cycle.
  - byte_idx  out  6  0-based index of the byte within the current frame.
  - frame_done  out  1  one-cycle strobe; frame ended with a valid stop bit.
  - frame_err  out  1  one-cycle strobe; frame aborted or malformed.
  - busy  out  1  high from the first falling edge of a frame until frame_done or frame_err.

## Operation
- data_in passes through a 2-flop synchronizer; both flops and the previous-sample register reset to 1.
- All timing below uses the synchronized line (sl).
- States:
  - SYNC (reset state):
    - counts consecutive sl=1 cycles and resets the count on any 0.
    - at IDLE_TIMEOUT, goes to IDLE.
    - no strobes.
  - IDLE: on sl falling edge, go to LOW; busy=1, bit and byte counters cleared, low_cnt=1.
  - LOW:
    - low_cnt increments each sl=0 cycle, saturating 16-bit.
    - On reaching LOW_MAX: frame_err, go to ERR_WAIT.
    - On sl rising edge: decode bit = (low_cnt < LOW_THRESH) ? 1 : 0, shift into an 8-bit shift register, increment the bit count, go to HIGH with high_cnt=1.
  - HIGH:
    - high_cnt increments each sl=1 cycle.
    - On sl falling edge: go to LOW, low_cnt=1.
    - On high_cnt reaching IDLE_TIMEOUT: end frame (see below).
  - ERR_WAIT: same as SYNC (IDLE_TIMEOUT consecutive high), then IDLE; no strobes.
- Byte completion:
  - When the 8th bit of a byte is decoded, raise byte_valid the next cycle.
  - byte_data = shift register contents; byte_idx = byte count.
  - Then increment the byte count and clear the bit count.
  - If byte count would exceed MAX_BYTES: frame_err instead of byte_valid, go to ERR_WAIT.
- Frame end at the idle timeout:
  - Valid only if exactly 1 leftover bit exists, that bit is 1 (the stop bit), and byte count ≥ 1. Then pulse frame_done.
  - Otherwise pulse frame_err.
  - Either way: busy=0, go to IDLE.
- Stop bit: never emitted as data.
- frame_done and frame_err: never asserted in the same cycle.

## Timing
- Reset values:
  - byte_data=0, byte_valid=0, byte_idx=0, frame_done=0, frame_err=0, busy=0.
  - State SYNC; synchronizer flops = 1.
- Latency:
  - Pin edges reach sl after 2 clk.
  - byte_valid is 1 cycle after the sl rising edge ending the 8th bit.
  - frame_done/frame_err is the cycle after high_cnt hits IDLE_TIMEOUT.
- Threshold boundaries:
  - low_cnt = LOW_THRESH-1 decodes 1; LOW_THRESH decodes 0.
  - low_cnt = LOW_MAX-1 is legal; LOW_MAX is an error.
- Reset asserted mid-frame:
  - All outputs clear immediately, with no strobe.
  - After release, the block stays in SYNC until the line has been high for IDLE_TIMEOUT; a partial frame in progress is silently dropped.
- A falling edge while in SYNC/ERR_WAIT only restarts the high count.
- All strobes are exactly one cycle wide; byte_data holds until the next byte_valid.

## Test plan
- Reset behaviour: line high, rst_n pulsed low mid-run → all outputs 0 during reset. A falling edge 100 cycles after release produces no strobe; block reaches IDLE only after 200 high cycles.
- Status command: send 0x00 (each bit 150 low/50 high), then stop (50 low), then high → one byte_valid with byte_data=0x00, byte_idx=0; frame_done 200 cycles after stop's sl rise; frame_err never.
- Three-byte write: send 0x03, 0x80, 0xA5, then stop → byte_valid ×3 with idx 0, 1, 2 and data as sent (1-bits 50 low/150 high); one frame_done.
- Threshold boundary: a bit with exactly 99 low cycles decodes 1 and 100 decodes 0. Send 0x55 using 99/100-cycle lows → byte_data=0x55.
- Long low mid-frame: after 3 bits hold low 250 cycles → frame_err at low_cnt=250, busy=0, no byte_valid. The next valid frame is decoded only after 200 high cycles.
- Malformed frame: 7 bits then idle → frame_err, no byte_valid. Byte plus 2 trailing bits → byte_valid then frame_err. 41 bytes → frame_err on byte 41.
